// File: rtl/spi_flash_pkg.sv
// Shared constants for the SPI flash-emulation command decoder:
// serial-flash opcodes, FSM state encodings and default identity bytes.
package spi_flash_pkg;

  // Serial-flash opcodes understood by the decoder
  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_RDSR      = 8'h05;
  localparam logic [7:0] OP_RDID      = 8'h9F;

  // Identity and status defaults
  localparam logic [23:0] DEFAULT_JEDEC_ID   = 24'hEF4018;
  localparam logic [7:0]  DEFAULT_STATUS_VAL = 8'h00;

  // Byte driven on MISO when there is nothing meaningful to send
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_DUMMY  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_STATUS = 3'd4;
  localparam logic [2:0] ST_ID     = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  // RDID response byte for a given index: JEDEC bytes MSB first, then fill
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = id[23:16];
      2'd1:    id_byte = id[15:8];
      2'd2:    id_byte = id[7:0];
      default: id_byte = FILL_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_cmd_if.sv
// Bundle between the command decoder, the SPI device byte ports and the
// backing-memory read port. The decoder uses the master view; the SPI
// device plus memory (or a testbench) use the slave view.
interface spi_flash_cmd_if #(
  parameter int ADDR_BITS = 24
) ();

  // SPI device side
  logic                 spi_cs;
  logic                 spi_rx_cmd;
  logic                 spi_rx_strobe;
  logic [7:0]           spi_rx_data;
  logic [7:0]           spi_tx_data;
  logic                 spi_tx_strobe;

  // Backing-memory read port
  logic                 rd_req;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 rd_valid;
  logic [7:0]           rd_data;

  // Command log
  logic [7:0]           cmd_opcode;
  logic                 cmd_valid;

  modport master (
    input  spi_cs, spi_rx_cmd, spi_rx_strobe, spi_rx_data, rd_valid, rd_data,
    output spi_tx_data, spi_tx_strobe, rd_req, rd_addr, cmd_opcode, cmd_valid
  );

  modport slave (
    output spi_cs, spi_rx_cmd, spi_rx_strobe, spi_rx_data, rd_valid, rd_data,
    input  spi_tx_data, spi_tx_strobe, rd_req, rd_addr, cmd_opcode, cmd_valid
  );

endinterface

// File: rtl/spi_flash_cmd.sv
// Flash-emulation command decoder. Decodes READ, RDSR and RDID opcodes
// arriving from the SPI device shift register, fetches image bytes from
// the backing memory and returns response bytes to the SPI transmit port.
// Optional feature macro: SPI_FAST_READ_EN adds FAST_READ (0x0B) with one
// dummy byte; without it 0x0B is treated as an unknown opcode.
module spi_flash_cmd
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_BITS  = 24,
  parameter logic [23:0] JEDEC_ID   = DEFAULT_JEDEC_ID,
  parameter logic [7:0]  STATUS_VAL = DEFAULT_STATUS_VAL
) (
  input  logic            clk,
  input  logic            reset,
  spi_flash_cmd_if.master bus
);

  logic [2:0] state;
  logic [1:0] addr_cnt;   // address byte index, 0..2
  logic [1:0] id_idx;     // next RDID byte index, saturates at 3 (fill)
  logic       rd_pend;    // a memory read is outstanding
`ifdef SPI_FAST_READ_EN
  logic       fast_rd;    // current read command needs a dummy byte
`endif

  logic opc_strobe;
  logic dat_strobe;

  assign opc_strobe = bus.spi_rx_strobe &  bus.spi_rx_cmd;
  assign dat_strobe = bus.spi_rx_strobe & ~bus.spi_rx_cmd;

  // Command FSM, address counter, read tracking and registered responses
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values and later assignments in this block win.
    if (reset) begin
      state             <= ST_IDLE;
      addr_cnt          <= 2'd0;
      id_idx            <= 2'd0;
      rd_pend           <= 1'b0;
`ifdef SPI_FAST_READ_EN
      fast_rd           <= 1'b0;
`endif
      bus.spi_tx_data   <= FILL_BYTE;
      bus.spi_tx_strobe <= 1'b0;
      bus.rd_req        <= 1'b0;
      bus.rd_addr       <= '0;
      bus.cmd_opcode    <= 8'h00;
      bus.cmd_valid     <= 1'b0;
    end else begin
      bus.spi_tx_strobe <= 1'b0;
      bus.rd_req        <= 1'b0;
      bus.cmd_valid     <= 1'b0;

      if (bus.spi_cs) begin
        // Deselect abandons everything, including a read still in flight
        state   <= ST_IDLE;
        rd_pend <= 1'b0;
      end else begin
        // NOTE: rd_valid is only honoured while a read is tracked, so a late reply to an abandoned read is silently dropped.
        if (rd_pend && bus.rd_valid && !opc_strobe) begin
          bus.spi_tx_strobe <= 1'b1;
          bus.spi_tx_data   <= bus.rd_data;
          rd_pend           <= 1'b0;
        end

        if (opc_strobe) begin
          bus.cmd_opcode <= bus.spi_rx_data;
          rd_pend        <= 1'b0;
          addr_cnt       <= 2'd0;
          id_idx         <= 2'd0;
          case (bus.spi_rx_data)
            OP_READ: begin
              state       <= ST_ADDR;
              bus.rd_addr <= '0;
`ifdef SPI_FAST_READ_EN
              fast_rd     <= 1'b0;
`endif
            end
`ifdef SPI_FAST_READ_EN
            OP_FAST_READ: begin
              state       <= ST_ADDR;
              bus.rd_addr <= '0;
              fast_rd     <= 1'b1;
            end
`endif
            OP_RDSR: begin
              state             <= ST_STATUS;
              bus.spi_tx_data   <= STATUS_VAL;
              bus.spi_tx_strobe <= 1'b1;
              bus.cmd_valid     <= 1'b1;
            end
            OP_RDID: begin
              state             <= ST_ID;
              bus.spi_tx_data   <= id_byte(JEDEC_ID, 2'd0);
              bus.spi_tx_strobe <= 1'b1;
              bus.cmd_valid     <= 1'b1;
              id_idx            <= 2'd1;
            end
            default: begin
              state             <= ST_IGNORE;
              bus.spi_tx_data   <= FILL_BYTE;
              bus.spi_tx_strobe <= 1'b1;
              bus.cmd_valid     <= 1'b1;
            end
          endcase
        end else if (dat_strobe) begin
          case (state)
            ST_ADDR: begin
              bus.rd_addr <= ADDR_BITS'({bus.rd_addr, bus.spi_rx_data});
              addr_cnt    <= addr_cnt + 2'd1;
              if (addr_cnt == 2'd2) begin
                bus.cmd_valid <= 1'b1;
`ifdef SPI_FAST_READ_EN
                if (fast_rd) begin
                  state <= ST_DUMMY;
                end else begin
                  state      <= ST_DATA;
                  bus.rd_req <= 1'b1;
                  rd_pend    <= 1'b1;
                end
`else
                state      <= ST_DATA;
                bus.rd_req <= 1'b1;
                rd_pend    <= 1'b1;
`endif
              end
            end
`ifdef SPI_FAST_READ_EN
            ST_DUMMY: begin
              state      <= ST_DATA;
              bus.rd_req <= 1'b1;
              rd_pend    <= 1'b1;
            end
`endif
            ST_DATA: begin
              // Only one read in flight; one completing this cycle frees the slot
              if (!rd_pend || bus.rd_valid) begin
                bus.rd_addr <= bus.rd_addr + ADDR_BITS'(1);
                bus.rd_req  <= 1'b1;
                rd_pend     <= 1'b1;
              end
            end
            ST_STATUS: begin
              bus.spi_tx_data   <= STATUS_VAL;
              bus.spi_tx_strobe <= 1'b1;
            end
            ST_ID: begin
              bus.spi_tx_data   <= id_byte(JEDEC_ID, id_idx);
              bus.spi_tx_strobe <= 1'b1;
              if (id_idx != 2'd3) begin
                id_idx <= id_idx + 2'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_cmd.sv
// Directed bench for spi_flash_cmd with scoreboard queues for transmit
// bytes, memory read addresses and logged opcodes. Honours
// SPI_FAST_READ_EN to pick the expected 0x0B behaviour.
module tb_spi_flash_cmd;
  import spi_flash_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_flash_cmd_if #(.ADDR_BITS(24)) bus ();

  spi_flash_cmd #(
    .ADDR_BITS (24),
    .JEDEC_ID  (24'hEF4018),
    .STATUS_VAL(8'h00)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  tx_q[$];
  logic [23:0] rd_q[$];
  logic [7:0]  cv_q[$];

  bit         mem_auto;
  int         man_cnt;
  int         man_seen;
  logic [7:0] man_data;

  // Memory image: a simple hash of the address
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h83;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares every DUT output pulse against the scoreboard queues
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        if (bus.spi_tx_strobe === 1'b1) begin
          check("tx_expected", (tx_q.size() != 0), 1);
          if (tx_q.size() != 0) check("tx_data", bus.spi_tx_data, tx_q.pop_front());
        end
        if (bus.rd_req === 1'b1) begin
          check("rd_expected", (rd_q.size() != 0), 1);
          if (rd_q.size() != 0) check("rd_addr", bus.rd_addr, rd_q.pop_front());
        end
        if (bus.cmd_valid === 1'b1) begin
          check("cv_expected", (cv_q.size() != 0), 1);
          if (cv_q.size() != 0) check("cmd_opcode", bus.cmd_opcode, cv_q.pop_front());
        end
      end
    end
  endtask

  // Memory model: 2-cycle latency on rd_req, or a one-shot manual reply
  task automatic responder();
    int         pend = 0;
    logic [23:0] lat_addr = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.rd_valid = 1'b0;
      if (man_cnt != man_seen) begin
        man_seen     = man_cnt;
        bus.rd_valid = 1'b1;
        bus.rd_data  = man_data;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.rd_valid = 1'b1;
          bus.rd_data  = mem_byte(lat_addr);
        end
      end else if (mem_auto && bus.rd_req === 1'b1) begin
        lat_addr = bus.rd_addr;
        pend     = 2;
      end
    end
  endtask

  task automatic send(input logic cmd, input logic [7:0] data);
    @(posedge clk);
    #1;
    bus.spi_rx_strobe = 1'b1;
    bus.spi_rx_cmd    = cmd;
    bus.spi_rx_data   = data;
    @(posedge clk);
    #1;
    bus.spi_rx_strobe = 1'b0;
    bus.spi_rx_cmd    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cs(input logic v);
    @(posedge clk);
    #1;
    bus.spi_cs = v;
  endtask

  task automatic drained(input string tag);
    check({tag, "_tx_left"}, tx_q.size(), 0);
    check({tag, "_rd_left"}, rd_q.size(), 0);
    check({tag, "_cv_left"}, cv_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tx_data"},   bus.spi_tx_data,   8'hFF);
    check({tag, "_tx_strobe"}, bus.spi_tx_strobe, 1'b0);
    check({tag, "_rd_req"},    bus.rd_req,        1'b0);
    check({tag, "_cmd_valid"}, bus.cmd_valid,     1'b0);
    check({tag, "_rd_addr"},   bus.rd_addr,       24'h0);
    check({tag, "_opcode"},    bus.cmd_opcode,    8'h00);
  endtask

  initial begin
    reset             = 1'b1;
    bus.spi_cs        = 1'b1;
    bus.spi_rx_cmd    = 1'b0;
    bus.spi_rx_strobe = 1'b0;
    bus.spi_rx_data   = 8'h00;
    bus.rd_valid      = 1'b0;
    bus.rd_data       = 8'h00;
    mem_auto          = 1'b1;
    man_cnt           = 0;
    man_seen          = 0;
    man_data          = 8'h00;

    fork
      monitor();
      responder();
    join_none

    // Reset values
    idle(3);
    check_reset_values("reset");
    reset = 1'b0;
    idle(2);

    // READ at 0x001234, then one more data byte
    set_cs(1'b0);
    send(1'b1, OP_READ);
    send(1'b0, 8'h00);
    send(1'b0, 8'h12);
    cv_q.push_back(OP_READ);
    rd_q.push_back(24'h001234);
    tx_q.push_back(8'hA5);
    send(1'b0, 8'h34);
    idle(6);
    check("read_opcode", bus.cmd_opcode, 8'h03);
    check("read_addr_held", bus.rd_addr, 24'h001234);
    rd_q.push_back(24'h001235);
    tx_q.push_back(mem_byte(24'h001235));
    send(1'b0, 8'h00);
    idle(6);
    check("read_addr_inc", bus.rd_addr, 24'h001235);
    set_cs(1'b1);
    idle(2);
    drained("read");

    // READ at the top of the address space wraps to zero
    set_cs(1'b0);
    send(1'b1, OP_READ);
    send(1'b0, 8'hFF);
    send(1'b0, 8'hFF);
    cv_q.push_back(OP_READ);
    rd_q.push_back(24'hFFFFFF);
    tx_q.push_back(8'h7C);
    send(1'b0, 8'hFF);
    idle(6);
    rd_q.push_back(24'h000000);
    tx_q.push_back(8'h83);
    send(1'b0, 8'h00);
    idle(6);
    rd_q.push_back(24'h000001);
    tx_q.push_back(8'h82);
    send(1'b0, 8'h00);
    idle(6);
    check("wrap_addr", bus.rd_addr, 24'h000001);
    set_cs(1'b1);
    idle(2);
    drained("wrap");

    // RDID: EF 40 18 then fill
    set_cs(1'b0);
    cv_q.push_back(OP_RDID);
    tx_q.push_back(8'hEF);
    send(1'b1, OP_RDID);
    tx_q.push_back(8'h40);
    send(1'b0, 8'h00);
    tx_q.push_back(8'h18);
    send(1'b0, 8'h00);
    tx_q.push_back(8'hFF);
    send(1'b0, 8'h00);
    tx_q.push_back(8'hFF);
    send(1'b0, 8'h00);
    idle(3);
    set_cs(1'b1);
    idle(2);
    drained("rdid");

    // Partial READ cut by deselect, then RDSR
    set_cs(1'b0);
    send(1'b1, OP_READ);
    send(1'b0, 8'h00);
    set_cs(1'b1);
    idle(3);
    set_cs(1'b0);
    cv_q.push_back(OP_RDSR);
    tx_q.push_back(8'h00);
    send(1'b1, OP_RDSR);
    tx_q.push_back(8'h00);
    send(1'b0, 8'hAA);
    idle(3);
    set_cs(1'b1);
    idle(2);
    drained("cut_rdsr");

    // Opcode 0x0B: FAST_READ when enabled, unknown otherwise
    set_cs(1'b0);
`ifdef SPI_FAST_READ_EN
    send(1'b1, OP_FAST_READ);
    send(1'b0, 8'h00);
    send(1'b0, 8'h00);
    cv_q.push_back(OP_FAST_READ);
    send(1'b0, 8'h10);
    idle(4);
    rd_q.push_back(24'h000010);
    tx_q.push_back(8'h93);
    send(1'b0, 8'h77);
    idle(6);
`else
    cv_q.push_back(8'h0B);
    tx_q.push_back(8'hFF);
    send(1'b1, 8'h0B);
    send(1'b0, 8'h00);
    send(1'b0, 8'h00);
    send(1'b0, 8'h10);
    send(1'b0, 8'h77);
    idle(6);
`endif
    set_cs(1'b1);
    idle(2);
    drained("op_0b");

    // Deselect in the same cycle as rd_valid: no transmit
    mem_auto = 1'b0;
    set_cs(1'b0);
    send(1'b1, OP_READ);
    send(1'b0, 8'h00);
    send(1'b0, 8'h00);
    cv_q.push_back(OP_READ);
    rd_q.push_back(24'h000020);
    send(1'b0, 8'h20);
    @(posedge clk);
    #1;
    man_data   = 8'h5A;
    man_cnt++;
    bus.spi_cs = 1'b1;
    idle(4);
    mem_auto = 1'b1;
    set_cs(1'b0);
    cv_q.push_back(OP_RDSR);
    tx_q.push_back(8'h00);
    send(1'b1, OP_RDSR);
    idle(3);
    set_cs(1'b1);
    idle(2);
    drained("cs_vs_valid");

    // Reset in the middle of DATA
    mem_auto = 1'b0;
    set_cs(1'b0);
    send(1'b1, OP_READ);
    send(1'b0, 8'h00);
    send(1'b0, 8'h00);
    cv_q.push_back(OP_READ);
    rd_q.push_back(24'h000040);
    send(1'b0, 8'h40);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    check_reset_values("mid_reset");
    reset    = 1'b0;
    man_data = 8'h66;
    man_cnt++;
    idle(4);
    mem_auto = 1'b1;
    cv_q.push_back(OP_RDSR);
    tx_q.push_back(8'h00);
    send(1'b1, OP_RDSR);
    idle(3);
    set_cs(1'b1);
    idle(2);
    drained("mid_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
